// File: rtl/tensor_commit_arb.sv
// Commit arbiter: round-robin over NUM_REQS sources with packet locking and a registered output beat.
// Optional sticky watchdog on over-long locked packets: define VX_TCARB_WATCHDOG_EN.
module tensor_commit_arb #(
  parameter int NUM_REQS  = 2,
  parameter int DATAW     = 64,
  parameter int MAX_BEATS = 8,
  localparam int SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       in_valid,
  output logic [NUM_REQS-1:0]       in_ready,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  input  logic [NUM_REQS-1:0]       in_sop,
  input  logic [NUM_REQS-1:0]       in_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [SEL_W-1:0]          out_sel
`ifdef VX_TCARB_WATCHDOG_EN
  ,
  output logic                      wd_err
`endif
);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lock_src_q, lock_src_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATAW-1:0]   out_data_q, out_data_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;

  logic [SEL_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               slot_free;
  logic               in_fire;
  logic [DATAW-1:0]   data_arr [NUM_REQS];
  logic               fire_sop;
  logic               fire_eop;

  assign slot_free = !out_valid_q || out_ready;

  // Unpack the flat payload bus and form per-source accepts.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_src
    assign data_arr[gi] = in_data[gi*DATAW +: DATAW];
    assign in_ready[gi] = reset && gnt_any && (gnt_idx == SEL_W'(gi)) && slot_free;
  end

  assign in_fire  = |(in_valid & in_ready);
  assign fire_sop = in_sop[gnt_idx];
  assign fire_eop = in_eop[gnt_idx];

  // Locked: stick to the owner. Unlocked: first valid at or above rr_ptr, else lowest valid (wrap).
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (state_q == LOCKED) begin
      gnt_idx = lock_src_q;
      gnt_any = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!gnt_any && in_valid[i] && (SEL_W'(i) >= rr_ptr_q)) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!gnt_any && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_src_d  = lock_src_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_sel_d   = out_sel_q;
    if (in_fire) begin
      if (state_q == UNLOCKED && fire_sop && !fire_eop) begin
        state_d    = LOCKED;
        lock_src_d = gnt_idx;
      end else if (state_q == LOCKED && fire_eop) begin
        state_d = UNLOCKED;
      end
      // Fairness advances only at packet boundaries.
      if (fire_eop) begin
        rr_ptr_d = (gnt_idx == SEL_W'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      out_valid_d = 1'b1;
      out_data_d  = data_arr[gnt_idx];
      out_sop_d   = fire_sop;
      out_eop_d   = fire_eop;
      out_sel_d   = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= UNLOCKED;
      lock_src_q  <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_src_q  <= lock_src_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_sel   = out_sel_q;

`ifdef VX_TCARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_err_q, wd_err_d;

  // The locking sop beat counts too, so the count equals beats of the open packet.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q;
    if (state_d == UNLOCKED) begin
      wd_cnt_d = '0;
    end else if (in_fire && (wd_cnt_q != CNT_W'(MAX_BEATS))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if (wd_cnt_d == CNT_W'(MAX_BEATS)) begin
      wd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`endif

endmodule

// File: tb/tb_tensor_commit_arb.sv
// Scoreboard bench for tensor_commit_arb: sources fed from beat queues, expected beats
// pushed in predicted arbitration order and popped on every output fire.
module tb_tensor_commit_arb;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [63:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   in_valid, in_ready, in_sop, in_eop;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_sop, out_eop;
  logic [63:0]  out_data;
  logic [0:0]   out_sel;
`ifdef VX_TCARB_WATCHDOG_EN
  logic         wd_err;
`endif

  always #5 clk = ~clk;

  tensor_commit_arb #(.NUM_REQS(2), .DATAW(64), .MAX_BEATS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_sel(out_sel)
`ifdef VX_TCARB_WATCHDOG_EN
    , .wd_err(wd_err)
`endif
  );

  beat_t        q0[$];
  beat_t        q1[$];
  logic [66:0]  exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           first_out, last_out;
  int           eop_cyc[2];
  logic [1:0]   s_in_ready;
  logic         s_out_valid;
  logic [63:0]  s_out_data;
  logic [0:0]   s_out_sel;
  logic         s_wd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int src, input logic sop, input logic eop,
                      input logic [63:0] d, input bit expect_out);
    beat_t b;
    b = '{sop: sop, eop: eop, data: d};
    if (src == 0) q0.push_back(b);
    else          q1.push_back(b);
    if (expect_out) exp_q.push_back({src[0], sop, eop, d});
  endtask

  task automatic cycle();
    logic [1:0]  fired;
    logic [66:0] e;
    beat_t       b;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    if (q0.size() > 0) begin
      in_valid[0] = 1'b1; in_sop[0] = q0[0].sop; in_eop[0] = q0[0].eop; in_data[63:0] = q0[0].data;
    end
    if (q1.size() > 0) begin
      in_valid[1] = 1'b1; in_sop[1] = q1[0].sop; in_eop[1] = q1[0].eop; in_data[127:64] = q1[0].data;
    end
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_out_sel   = out_sel;
`ifdef VX_TCARB_WATCHDOG_EN
    s_wd = wd_err;
`else
    s_wd = 1'b0;
`endif
    if (out_valid && out_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      $display("out cyc=%0d sel=%0d sop=%0b eop=%0b data=%h", cyc, out_sel, out_sop, out_eop, out_data);
      check("out_beat", {out_sel, out_sop, out_eop, out_data}, e);
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    fired = in_valid & in_ready;
    @(posedge clk);
    if (fired[0]) begin
      b = q0.pop_front();
      if (b.eop) eop_cyc[0] = cyc;
    end
    if (fired[1]) begin
      b = q1.pop_front();
      if (b.eop) eop_cyc[1] = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drained", exp_q.size() + q0.size() + q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    first_out = -1; last_out = -1; eop_cyc[0] = 0; eop_cyc[1] = 0;
    @(negedge clk);

    // Reset: sources present beats but must not be accepted
    send(0, 1'b1, 1'b1, 64'h11, 1'b0);
    send(1, 1'b1, 1'b1, 64'h22, 1'b0);
    cycle();
    cycle();
    check("rst_in_ready", s_in_ready, 2'b00);
    check("rst_out_valid", s_out_valid, 1'b0);
    check("rst_out_data", s_out_data, 64'h0);
    check("rst_out_sel", s_out_sel, 1'b0);
    check("rst_sop_eop", {out_sop, out_eop}, 2'b00);
    q0.delete(); q1.delete();
    reset = 1'b1;

    // Single source 4-beat packet: 1-cycle latency, 4 back-to-back beats
    first_out = -1; t = cyc;
    for (int b = 0; b < 4; b++) send(0, b == 0, b == 3, 64'hA000 + 64'(b), 1'b1);
    drain(20);
    check("t1_latency", first_out - t, 1);
    check("t1_span", last_out - first_out, 3);

    // No interleave: source 1 appears one cycle in, waits for source 0 eop
    t = cyc;
    for (int b = 0; b < 4; b++) send(0, b == 0, b == 3, 64'hB000 + 64'(b), 1'b1);
    cycle();
    send(1, 1'b1, 1'b1, 64'hB100, 1'b1);
    drain(20);
    check("t2_src0_eop", eop_cyc[0] - t, 3);
    check("t2_src1_gap", eop_cyc[1] - eop_cyc[0], 1);

    // Fairness: single-beat packets from both sources alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      send(0, 1'b1, 1'b1, 64'hC000 + 64'(k), 1'b1);
      send(1, 1'b1, 1'b1, 64'hC100 + 64'(k), 1'b1);
    end
    drain(30);

    // Backpressure mid-packet: output held, no accepts, nothing lost or duplicated
    for (int b = 0; b < 4; b++) send(0, b == 0, b == 3, 64'hD000 + 64'(b), 1'b1);
    send(1, 1'b1, 1'b1, 64'hD100, 1'b1);
    for (int c = 0; c < 30 && (exp_q.size() > 0); c++) begin
      out_ready = !(c >= 3 && c <= 5);
      cycle();
      if (c >= 3 && c <= 5) begin
        check("bp_in_ready", s_in_ready, 2'b00);
        check("bp_out_valid", s_out_valid, 1'b1);
        check("bp_out_data", s_out_data, 64'hD002);
      end
    end
    out_ready = 1'b1;
    drain(5);

    // Reset mid-packet abandons the lock; source 1 is granted right after release
    send(0, 1'b1, 1'b0, 64'hE000, 1'b1);
    send(0, 1'b0, 1'b0, 64'hE001, 1'b1);
    send(0, 1'b0, 1'b0, 64'hE002, 1'b0);
    send(0, 1'b0, 1'b1, 64'hE003, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("t5_rst_in_ready", s_in_ready, 2'b00);
    cycle();
    check("t5_out_valid", s_out_valid, 1'b0);
    q0.delete();
    reset = 1'b1;
    send(1, 1'b1, 1'b1, 64'hE100, 1'b1);
    cycle();
    check("t5_grant", s_in_ready, 2'b10);
    drain(5);

`ifdef VX_TCARB_WATCHDOG_EN
    // Watchdog: 8 beats without eop set a sticky error
    for (int b = 0; b < 8; b++) send(0, b == 0, 1'b0, 64'hF000 + 64'(b), 1'b1);
    for (int c = 0; c < 12; c++) begin
      cycle();
      check("wd_err", s_wd, (c >= 8) ? 1'b1 : 1'b0);
    end
    check("wd_drained", exp_q.size(), 0);
    reset = 1'b0;
    cycle();
    cycle();
    check("wd_err_rst", s_wd, 1'b0);
    reset = 1'b1;
    cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
